// File: rtl/spi_reg_slave_pkg.sv
// Shared definitions for the SPI register-bus slave:
// frame field positions and FSM state encoding.
package spi_reg_slave_pkg;

  localparam int FRAME_BITS = 48;
  localparam int DATA_W     = 32;
  localparam int RW_BIT     = 47;
  localparam int ADDR_MSB   = 43;
  localparam int ADDR_LSB   = 32;
  localparam int HDR_BITS   = FRAME_BITS - DATA_W;

  // Header field positions inside the 16-bit header word
  localparam int HDR_RW   = RW_BIT - DATA_W;
  localparam int HDR_ADDR = ADDR_LSB - DATA_W;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HDR    = 3'd1;
  localparam state_t S_RD_REQ = 3'd2;
  localparam state_t S_RD_CAP = 3'd3;
  localparam state_t S_DATA   = 3'd4;
  localparam state_t S_DONE   = 3'd5;

endpackage

// File: rtl/spi_reg_slave_if.sv
// BRAM-style register bus between the SPI slave
// and the trigger-logic register mux.
interface spi_reg_slave_if;
  import spi_reg_slave_pkg::*;

  logic [31:0]       addr;
  logic [3:0]        be;
  logic              rd;
  logic [DATA_W-1:0] data_wr;
  logic [DATA_W-1:0] data_rd;

  modport master (
    output addr,
    output be,
    output rd,
    output data_wr,
    input  data_rd
  );

  modport slave (
    input  addr,
    input  be,
    input  rd,
    input  data_wr,
    output data_rd
  );

endinterface

// File: rtl/spi_reg_slave_pin_sync.sv
// Synchronizes the SPI pins into io_clk and
// produces single-cycle SCK and SS_N edge pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic ss_n,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic ss_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_q;
  logic [SYNC_STAGES-1:0] ss_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sck_d;
  logic                   ss_d;

  // SS_N chain resets low so a frame already in progress
  // at reset release produces no falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      sck_d  <= 1'b0;
      ss_d   <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_n};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_q[SYNC_STAGES-1];
      ss_d   <= ss_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
  assign ss_rise  = ss_q[SYNC_STAGES-1] & ~ss_d;
  assign ss_fall  = ~ss_q[SYNC_STAGES-1] & ss_d;
  assign ss_n_s   = ss_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave turning 48-bit frames into single
// accesses on the trigger-logic register bus.
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic           io_clk,
  input  logic           io_rst,
  input  logic           io_spi_sck,
  input  logic           io_spi_ss_n,
  input  logic           io_spi_mosi,
  output logic           io_spi_miso,
  output logic           io_spi_miso_oe,
  spi_reg_slave_if.master bus,
  output logic           io_frame_err
);

  localparam logic [5:0] HDR_LAST = 6'(HDR_BITS - 1);
  localparam logic [5:0] FRM_LAST = 6'(FRAME_BITS - 1);

  logic sck_rise;
  logic sck_fall;
  logic ss_rise;
  logic ss_fall;
  logic ss_n_s;
  logic mosi_s;

  state_t            state;
  logic [5:0]        cnt;
  logic [DATA_W-2:0] sh;
  logic [DATA_W:0]   tx;
  logic              rw;
  logic              armed;
  logic [DATA_W-1:0] nxt;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (io_clk),
    .rst      (io_rst),
    .sck      (io_spi_sck),
    .ss_n     (io_spi_ss_n),
    .mosi     (io_spi_mosi),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_rise  (ss_rise),
    .ss_fall  (ss_fall),
    .ss_n_s   (ss_n_s),
    .mosi_s   (mosi_s)
  );

  assign nxt = {sh, mosi_s};

  // tx carries a leading zero so a freshly loaded word
  // shows bit31 only after the next falling edge.
  assign io_spi_miso    = tx[DATA_W];
  assign io_spi_miso_oe = armed & ~ss_n_s;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      sh           <= '0;
      tx           <= '0;
      rw           <= 1'b0;
      armed        <= 1'b0;
      io_frame_err <= 1'b0;
      bus.addr     <= '0;
      bus.be       <= '0;
      bus.rd       <= 1'b0;
      bus.data_wr  <= '0;
    end else begin
      bus.be <= '0;
      bus.rd <= 1'b0;
      if (ss_rise)
        armed <= 1'b1;
      if (sck_fall)
        tx <= {tx[DATA_W-1:0], 1'b0};
      if (sck_rise)
        sh <= nxt[DATA_W-2:0];
      unique case (state)
        S_IDLE: begin
          if (ss_fall) begin
            cnt   <= '0;
            tx    <= '0;
            state <= S_HDR;
          end
        end
        S_HDR: begin
          if (ss_rise) begin
            io_frame_err <= 1'b1;
            state        <= S_IDLE;
          end else if (sck_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == HDR_LAST) begin
              rw       <= nxt[HDR_RW];
              bus.addr <= 32'(nxt[HDR_ADDR +: ADDR_W]);
              if (nxt[HDR_RW]) begin
                state <= S_DATA;
              end else begin
                bus.rd <= 1'b1;
                state  <= S_RD_REQ;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (ss_rise) begin
            io_frame_err <= 1'b1;
            state        <= S_IDLE;
          end else begin
            state <= S_RD_CAP;
          end
        end
        S_RD_CAP: begin
          if (ss_rise) begin
            io_frame_err <= 1'b1;
            state        <= S_IDLE;
          end else begin
            tx    <= {1'b0, bus.data_rd};
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (ss_rise) begin
            io_frame_err <= 1'b1;
            state        <= S_IDLE;
          end else if (sck_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == FRM_LAST) begin
              if (rw) begin
                bus.be      <= 4'hF;
                bus.data_wr <= nxt;
              end
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (ss_rise) begin
            io_frame_err <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed and random frames against a register-bus
// reference model for spi_reg_slave.
module tb_spi_reg_slave;

  localparam int HALF = 40;

  logic clk;
  logic rst;
  logic sck;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic frame_err;

  spi_reg_slave_if bus ();

  spi_reg_slave #(
    .ADDR_W      (12),
    .SYNC_STAGES (2)
  ) dut (
    .io_clk         (clk),
    .io_rst         (rst),
    .io_spi_sck     (sck),
    .io_spi_ss_n    (ss_n),
    .io_spi_mosi    (mosi),
    .io_spi_miso    (miso),
    .io_spi_miso_oe (miso_oe),
    .bus            (bus),
    .io_frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int          be_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] rd_addr = '0;

  logic [31:0] bus_mem [logic [11:0]];
  logic [31:0] exp_mem [logic [11:0]];

  function automatic logic [31:0] seed_val(input logic [11:0] a);
    if (a == 12'h045)
      return 32'h0BADF00D;
    return 32'h9E3779B9 * (32'(a) + 32'd1);
  endfunction

  function automatic logic [31:0] bus_val(input logic [11:0] a);
    if (bus_mem.exists(a))
      return bus_mem[a];
    return seed_val(a);
  endfunction

  function automatic logic [31:0] exp_val(input logic [11:0] a);
    if (exp_mem.exists(a))
      return exp_mem[a];
    return seed_val(a);
  endfunction

  // Register-bus slave: read data one cycle after rd
  always @(posedge clk) begin
    if (rst) begin
      bus.data_rd <= '0;
    end else begin
      if (bus.rd === 1'b1) begin
        bus.data_rd <= bus_val(bus.addr[11:0]);
        rd_cnt++;
        rd_addr = bus.addr;
      end
      if (bus.be !== 4'h0) begin
        be_cnt++;
        wr_addr = bus.addr;
        wr_data = bus.data_wr;
        wr_be   = bus.be;
        bus_mem[bus.addr[11:0]] = bus.data_wr;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_addr"}, 64'(bus.addr), 64'h0);
    chk({tag, "_be"}, 64'(bus.be), 64'h0);
    chk({tag, "_rd"}, 64'(bus.rd), 64'h0);
    chk({tag, "_wdata"}, 64'(bus.data_wr), 64'h0);
    chk({tag, "_miso"}, 64'(miso), 64'h0);
    chk({tag, "_oe"}, 64'(miso_oe), 64'h0);
    chk({tag, "_err"}, 64'(frame_err), 64'h0);
  endtask

  // One frame as an SPI mode-0 master; rst_at >= 0 pulses io_rst
  task automatic xfer(input logic [47:0] f, input int nbits,
                      input int rst_at, output logic [47:0] got,
                      output logic extra_nz);
    got      = '0;
    extra_nz = 1'b0;
    sck      = 1'b0;
    ss_n     = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 48) ? f[47-i] : 1'b0;
      if (i == rst_at) begin
        rst = 1'b1;
        #20;
        chk_reset_outs("midrst");
        rst = 1'b0;
        #20;
      end else begin
        #(HALF);
      end
      if (i == 0 && rst_at < 0)
        chk("oe_active", 64'(miso_oe), 64'h1);
      if (i < 48)
        got[47-i] = miso;
      else if (miso !== 1'b0)
        extra_nz = 1'b1;
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
    end
    #(HALF);
    ss_n = 1'b1;
    #30;
    chk("oe_release", 64'(miso_oe), 64'h0);
    #130;
  endtask

  task automatic run_good(input logic rw, input logic [2:0] rsv,
                          input logic [11:0] a, input logic [31:0] d,
                          input int nbits);
    logic [47:0] got;
    logic        xnz;
    int          be0;
    int          rd0;
    logic [47:0] exp_got;
    be0 = be_cnt;
    rd0 = rd_cnt;
    exp_got = rw ? 48'h0 : {16'h0, exp_val(a)};
    xfer({rw, rsv, a, d}, nbits, -1, got, xnz);
    chk("miso_frame", 64'(got), 64'(exp_got));
    chk("err_clear", 64'(frame_err), 64'h0);
    chk("miso_extra", 64'(xnz), 64'h0);
    if (rw) begin
      exp_mem[a] = d;
      chk("wr_count", 64'(be_cnt - be0), 64'h1);
      chk("wr_no_rd", 64'(rd_cnt - rd0), 64'h0);
      chk("wr_be", 64'(wr_be), 64'hF);
      chk("wr_addr", 64'(wr_addr), 64'(a));
      chk("wr_data", 64'(wr_data), 64'(d));
    end else begin
      chk("rd_count", 64'(rd_cnt - rd0), 64'h1);
      chk("rd_no_wr", 64'(be_cnt - be0), 64'h0);
      chk("rd_addr", 64'(rd_addr), 64'(a));
    end
  endtask

  initial begin
    logic [47:0] got;
    logic        xnz;
    int          be0;
    int          rd0;
    logic        rw;
    logic [2:0]  rsv;
    logic [11:0] a;
    logic [31:0] d;

    rst  = 1'b1;
    ss_n = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    #30;
    chk_reset_outs("reset");
    rst = 1'b0;
    #100;

    run_good(1'b1, 3'b000, 12'h123, 32'hDEADBEEF, 48);
    run_good(1'b0, 3'b000, 12'h045, 32'h00000000, 48);

    be0 = be_cnt;
    xfer(48'h8_456_CAFEF00D, 30, -1, got, xnz);
    chk("abort_no_wr", 64'(be_cnt - be0), 64'h0);
    chk("abort_err", 64'(frame_err), 64'h1);
    run_good(1'b1, 3'b000, 12'h456, 32'h12345678, 48);

    be0 = be_cnt;
    rd0 = rd_cnt;
    xfer(48'h8_789_A5A5A5A5, 48, 40, got, xnz);
    chk("rst_no_wr", 64'(be_cnt - be0), 64'h0);
    chk("rst_no_rd", 64'(rd_cnt - rd0), 64'h0);
    chk("rst_err", 64'(frame_err), 64'h0);
    chk("rst_addr", 64'(bus.addr), 64'h0);
    run_good(1'b1, 3'b000, 12'h789, 32'h0F0F1234, 48);

    run_good(1'b1, 3'b000, 12'h0AB, 32'h87654321, 56);
    run_good(1'b0, 3'b000, 12'h0AB, 32'h00000000, 56);

    be0 = be_cnt;
    rd0 = rd_cnt;
    ss_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sck = 1'b1;
      #(HALF);
      sck = 1'b0;
      #(HALF);
    end
    #100;
    chk("idle_no_wr", 64'(be_cnt - be0), 64'h0);
    chk("idle_no_rd", 64'(rd_cnt - rd0), 64'h0);
    chk("idle_oe", 64'(miso_oe), 64'h0);

    for (int k = 0; k < 24; k++) begin
      rw  = 1'($urandom_range(0, 1));
      rsv = 3'($urandom);
      a   = 12'($urandom_range(0, 31));
      d   = $urandom;
      run_good(rw, rsv, a, d, 48);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
